// File: rtl/vsfx_pkg.sv
// vsfx_pkg: shared types and constants for the VSFX halfword-average sequencer.
//   state_t      : sequencer state (IDLE, BUSY, DONE)
//   VSFX_VLEN    : vector register width (bits)
//   VSFX_SLICE_W : width of one processed slice (two halfwords)
//   VSFX_HW_W    : halfword width
//   avg_hw()     : rounded halfword average, signed or unsigned
package vsfx_pkg;

  localparam int unsigned VSFX_VLEN    = 128;
  localparam int unsigned VSFX_SLICE_W = 32;
  localparam int unsigned VSFX_HW_W    = 16;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  // Extend to 17 bits so a + b + 1 cannot overflow; bit 16 of the sum
  // becomes the result MSB, which yields an arithmetic shift for signed
  // operands and a logical shift for unsigned ones.
  function automatic logic [VSFX_HW_W-1:0] avg_hw(input logic [VSFX_HW_W-1:0] a,
                                                   input logic [VSFX_HW_W-1:0] b,
                                                   input logic             sgn);
    logic [VSFX_HW_W:0] ea;
    logic [VSFX_HW_W:0] eb;
    logic [VSFX_HW_W:0] sum;
    ea  = {sgn & a[VSFX_HW_W-1], a};
    eb  = {sgn & b[VSFX_HW_W-1], b};
    sum = ea + eb + (VSFX_HW_W+1)'(1);
    return sum[VSFX_HW_W:1];
  endfunction

endpackage

// File: rtl/vsfx_vavgh_seq_if.sv
// vsfx_vavgh_seq_if: operand/result handshake bundle for vsfx_vavgh_seq.
//   in_valid/in_ready   : operand pair handshake
//   in_signed           : 1 = vavgsh, 0 = vavguh
//   vra, vrb            : operands (VLEN bits)
//   out_valid/out_ready : result handshake
//   vrt                 : result (VLEN bits)
// Modports: master = issue side / writeback side (drives operands, out_ready),
//           slave  = the sequencer.
interface vsfx_vavgh_seq_if
  import vsfx_pkg::*;
#(
  parameter int unsigned VLEN = VSFX_VLEN
);

  logic            in_valid;
  logic            in_ready;
  logic            in_signed;
  logic [VLEN-1:0] vra;
  logic [VLEN-1:0] vrb;
  logic            out_valid;
  logic            out_ready;
  logic [VLEN-1:0] vrt;

  modport master (
    output in_valid, in_signed, vra, vrb, out_ready,
    input  in_ready, out_valid, vrt
  );

  modport slave (
    input  in_valid, in_signed, vra, vrb, out_ready,
    output in_ready, out_valid, vrt
  );

endinterface

// File: rtl/vsfx_vavgh_slice.sv
// vsfx_vavgh_slice: combinational rounded average of two halfword lanes.
//   a, b      : 32-bit operand slices (halfword 0 in [15:0], halfword 1 in [31:16])
//   is_signed : 1 = signed average, 0 = unsigned
//   t         : 32-bit result slice, same lane layout
module vsfx_vavgh_slice
  import vsfx_pkg::*;
(
  input  logic [VSFX_SLICE_W-1:0] a,
  input  logic [VSFX_SLICE_W-1:0] b,
  input  logic                    is_signed,
  output logic [VSFX_SLICE_W-1:0] t
);

  localparam int unsigned NHW = VSFX_SLICE_W / VSFX_HW_W;

  always_comb begin
    t = '0;
    for (int unsigned h = 0; h < NHW; h++) begin
      t[h*VSFX_HW_W +: VSFX_HW_W] = avg_hw(a[h*VSFX_HW_W +: VSFX_HW_W],
                                           b[h*VSFX_HW_W +: VSFX_HW_W],
                                           is_signed);
    end
  end

endmodule

// File: rtl/vsfx_vavgh_seq.sv
// vsfx_vavgh_seq: multi-cycle halfword averager over a full vector register.
// Latches a vra/vrb pair, pushes one 32-bit slice per cycle through a single
// vsfx_vavgh_slice, reassembles vrt and holds it under out_valid until taken.
//   clk, rst : clock, synchronous active-high reset
//   bus      : vsfx_vavgh_seq_if.slave (operand and result handshakes)
//   VLEN     : vector width, must be a multiple of 32
// Build option VSFX_VAVGH_SEQ_B2B_EN: accept the next operand pair in the same
// cycle the result is taken (DONE -> BUSY), removing the idle bubble.
module vsfx_vavgh_seq
  import vsfx_pkg::*;
#(
  parameter int unsigned VLEN = VSFX_VLEN
) (
  input  logic           clk,
  input  logic           rst,
  vsfx_vavgh_seq_if.slave bus
);

  localparam int unsigned NSLICE = VLEN / VSFX_SLICE_W;
  localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [CNT_W-1:0]        r_cnt;
  logic [VLEN-1:0]         r_vra;
  logic [VLEN-1:0]         r_vrb;
  logic [VLEN-1:0]         r_res;
  logic                    r_sgn;
  logic                    w_in_ready;
  logic                    w_out_valid;
  logic                    w_accept;
  logic                    w_last;
  logic [VSFX_SLICE_W-1:0] w_a;
  logic [VSFX_SLICE_W-1:0] w_b;
  logic [VSFX_SLICE_W-1:0] w_t;

  assign w_last   = (r_cnt == CNT_W'(NSLICE - 1));
  assign w_accept = w_in_ready & bus.in_valid;

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_state_nxt = BUSY;
      end
      BUSY: begin
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        w_out_valid = 1'b1;
`ifdef VSFX_VAVGH_SEQ_B2B_EN
        w_in_ready = bus.out_ready;
        if (bus.out_ready) w_state_nxt = bus.in_valid ? BUSY : IDLE;
`else
        if (bus.out_ready) w_state_nxt = IDLE;
`endif
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Slice select by counter; constant-index mux keeps index widths exact.
  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int unsigned s = 0; s < NSLICE; s++) begin
      if (r_cnt == CNT_W'(s)) begin
        w_a = r_vra[s*VSFX_SLICE_W +: VSFX_SLICE_W];
        w_b = r_vrb[s*VSFX_SLICE_W +: VSFX_SLICE_W];
      end
    end
  end

  vsfx_vavgh_slice u_slice (
    .a         (w_a),
    .b         (w_b),
    .is_signed (r_sgn),
    .t         (w_t)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_vra   <= '0;
      r_vrb   <= '0;
      r_sgn   <= 1'b0;
      r_res   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_vra <= bus.vra;
        r_vrb <= bus.vrb;
        r_sgn <= bus.in_signed;
        r_cnt <= '0;
      end else if (r_state == BUSY) begin
        for (int unsigned s = 0; s < NSLICE; s++) begin
          if (r_cnt == CNT_W'(s)) r_res[s*VSFX_SLICE_W +: VSFX_SLICE_W] <= w_t;
        end
        r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.vrt       = r_res;

endmodule

// File: tb/tb_vsfx_vavgh_seq.sv
// tb_vsfx_vavgh_seq: self-checking bench for vsfx_vavgh_seq.
// A transaction-level model (queue of expected results with acceptance cycle)
// predicts in_ready, out_valid and vrt every cycle; directed cases pin literal
// results, latency, backpressure, mid-operation reset and back-to-back spacing.
module tb_vsfx_vavgh_seq;
  import vsfx_pkg::*;

  localparam int unsigned VLEN   = VSFX_VLEN;
  localparam int unsigned NSLICE = VLEN / 32;
  localparam int unsigned NHW    = VLEN / 16;
`ifdef VSFX_VAVGH_SEQ_B2B_EN
  localparam bit          B2B    = 1'b1;
  localparam int unsigned PERIOD = NSLICE + 1;
`else
  localparam bit          B2B    = 1'b0;
  localparam int unsigned PERIOD = NSLICE + 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  vsfx_vavgh_seq_if #(.VLEN(VLEN)) bus ();

  vsfx_vavgh_seq #(.VLEN(VLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [VLEN-1:0] res;
    int unsigned     ca;
  } txn_t;

  txn_t        q[$];
  int unsigned pop_cycs[$];
  int unsigned cyc     = 0;
  int unsigned n_vec   = 0;
  int unsigned n_err   = 0;
  int unsigned acc_cyc = 0;
  logic        rst_at_edge = 1'b1;
  bit          rand_ordy   = 1'b0;

  // Reference: rounded average of each halfword using plain integers.
  function automatic logic [VLEN-1:0] ref_avg(input logic s, input logic [VLEN-1:0] a,
                                              input logic [VLEN-1:0] b);
    logic [VLEN-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < NHW; i++) begin
      int x;
      int y;
      int sum;
      x   = s ? int'($signed(a[16*i +: 16])) : int'(a[16*i +: 16]);
      y   = s ? int'($signed(b[16*i +: 16])) : int'(b[16*i +: 16]);
      sum = x + y + 1;
      r[16*i +: 16] = 16'(sum >>> 1);
    end
    return r;
  endfunction

  function automatic logic [VLEN-1:0] fill(input logic [15:0] h);
    logic [VLEN-1:0] r;
    for (int unsigned i = 0; i < NHW; i++) r[16*i +: 16] = h;
    return r;
  endfunction

  function automatic logic [VLEN-1:0] rand_vec();
    logic [VLEN-1:0] r;
    logic [15:0]     c[5];
    c = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
    for (int unsigned i = 0; i < NHW; i++)
      r[16*i +: 16] = ($urandom_range(0, 1) == 1) ? c[$urandom_range(0, 4)] : 16'($urandom);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s @cyc %0d: bound expired", nm, cyc);
  endtask

  initial begin
    @(posedge clk);
    forever begin
      rst_at_edge = rst;
      @(posedge clk);
    end
  end

  // Per-cycle comparison against the transaction model.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_at_edge) begin
        q.delete();
        chk("rst_in_ready",  VLEN'(bus.in_ready),  VLEN'(1'b1));
        chk("rst_out_valid", VLEN'(bus.out_valid), VLEN'(1'b0));
        chk("rst_vrt",       bus.vrt,              '0);
        if (bus.in_valid && !rst)
          q.push_back('{res: ref_avg(bus.in_signed, bus.vra, bus.vrb), ca: cyc});
      end else begin
        bit exp_ov;
        bit exp_ir;
        exp_ov = (q.size() > 0) && (cyc >= q[0].ca + NSLICE + 1);
        exp_ir = (q.size() == 0) || (B2B && exp_ov && bus.out_ready);
        chk("out_valid", VLEN'(bus.out_valid), VLEN'(exp_ov));
        chk("in_ready",  VLEN'(bus.in_ready),  VLEN'(exp_ir));
        if (exp_ov) chk("vrt", bus.vrt, q[0].res);
        if (exp_ov && bus.out_ready) begin
          void'(q.pop_front());
          pop_cycs.push_back(cyc);
        end
        if (bus.in_valid && exp_ir)
          q.push_back('{res: ref_avg(bus.in_signed, bus.vra, bus.vrb), ca: cyc});
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rand_ordy) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic s, input logic [VLEN-1:0] a, input logic [VLEN-1:0] b,
                      input bit hold);
    bit acc;
    acc           = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_signed = s;
    bus.vra       = a;
    bus.vrb       = b;
    for (int k = 0; k < 60 && !acc; k++) begin
      @(negedge clk);
      #1;
      acc = bus.in_ready;
      if (acc) acc_cyc = cyc;
      @(posedge clk);
      #1;
    end
    if (!acc) fail_now("accept_timeout");
    if (!hold) begin
      bus.in_valid  = 1'b0;
      bus.in_signed = ~s;
      bus.vra       = rand_vec();
      bus.vrb       = rand_vec();
    end
  endtask

  task automatic wait_ov(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      #1;
      if (bus.out_valid) seen = 1'b1;
    end
    if (!seen) fail_now("out_valid_timeout");
  endtask

  task automatic run_lit(input string nm, input logic s, input logic [VLEN-1:0] a,
                         input logic [VLEN-1:0] b, input logic [VLEN-1:0] exp);
    bit seen;
    send(s, a, b, 1'b0);
    wait_ov(seen);
    if (seen) begin
      chk({nm, "_lat"}, VLEN'(cyc - acc_cyc), VLEN'(NSLICE + 1));
      chk(nm, bus.vrt, exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 400 && q.size() != 0; k++) begin
      @(negedge clk);
      #1;
    end
    if (q.size() != 0) fail_now("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit          seen;
    int unsigned n_b2b;
    bus.in_valid  = 1'b0;
    bus.in_signed = 1'b0;
    bus.vra       = '0;
    bus.vrb       = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Model pins.
    chk("model_s_7fff", ref_avg(1'b1, fill(16'h7FFF), fill(16'h8000)), fill(16'h0000));
    chk("model_u_ffff", ref_avg(1'b0, fill(16'hFFFF), fill(16'h0001)), fill(16'h8000));

    run_lit("s_7fff_7fff", 1'b1, fill(16'h7FFF), fill(16'h7FFF), fill(16'h7FFF));
    run_lit("s_8000_8000", 1'b1, fill(16'h8000), fill(16'h8000), fill(16'h8000));
    run_lit("s_ffff_0001", 1'b1, fill(16'hFFFF), fill(16'h0001), fill(16'h0000));
    run_lit("s_7fff_8000", 1'b1, fill(16'h7FFF), fill(16'h8000), fill(16'h0000));
    run_lit("s_0001_0002", 1'b1, fill(16'h0001), fill(16'h0002), fill(16'h0002));
    run_lit("u_ffff_0001", 1'b0, fill(16'hFFFF), fill(16'h0001), fill(16'h8000));
    run_lit("u_7fff_8000", 1'b0, fill(16'h7FFF), fill(16'h8000), fill(16'h8000));
    run_lit("lane_zero", 1'b0, 128'h0007_0006_0005_0004_0003_0002_0001_0000, '0,
            128'h0004_0003_0003_0002_0002_0001_0001_0000);
    run_lit("lane_self", 1'b0, 128'h0007_0006_0005_0004_0003_0002_0001_0000,
            128'h0007_0006_0005_0004_0003_0002_0001_0000,
            128'h0007_0006_0005_0004_0003_0002_0001_0000);

    // Backpressure: result held for 10 cycles, then released.
    bus.out_ready = 1'b0;
    send(1'b0, fill(16'h1234), fill(16'h5678), 1'b0);
    wait_ov(seen);
    for (int k = 0; k < 10; k++) begin
      chk("bp_vrt",       bus.vrt,              fill(16'h3456));
      chk("bp_out_valid", VLEN'(bus.out_valid), VLEN'(1'b1));
      chk("bp_in_ready",  VLEN'(bus.in_ready),  VLEN'(1'b0));
      @(negedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    #1;
    chk("bp_rel_out_valid", VLEN'(bus.out_valid), VLEN'(1'b0));
    chk("bp_rel_in_ready",  VLEN'(bus.in_ready),  VLEN'(1'b1));
    @(posedge clk);
    #1;

    // Reset during the second BUSY cycle.
    send(1'b1, fill(16'h7FFF), fill(16'h0001), 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("abort_in_ready",  VLEN'(bus.in_ready),  VLEN'(1'b1));
    chk("abort_out_valid", VLEN'(bus.out_valid), VLEN'(1'b0));
    chk("abort_vrt",       bus.vrt,              '0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      chk("abort_quiet", VLEN'(bus.out_valid), VLEN'(1'b0));
    end
    @(posedge clk);
    #1;
    run_lit("post_abort", 1'b1, fill(16'h7FFF), fill(16'h0001), fill(16'h4000));

    // Back-to-back with in_valid held high.
    pop_cycs.delete();
    n_b2b = 6;
    for (int unsigned k = 0; k < n_b2b; k++)
      send(1'(($urandom_range(0, 1))), rand_vec(), rand_vec(), 1'b1);
    bus.in_valid = 1'b0;
    wait_drain();
    chk("b2b_count", VLEN'(pop_cycs.size()), VLEN'(n_b2b));
    for (int unsigned k = 1; k < pop_cycs.size(); k++)
      chk("b2b_gap", VLEN'(pop_cycs[k] - pop_cycs[k-1]), VLEN'(PERIOD));

    // Randomized traffic with random backpressure and idle gaps.
    rand_ordy = 1'b1;
    for (int unsigned t = 0; t < 150; t++) begin
      int unsigned gap;
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        bus.in_signed = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
      end
      send(1'($urandom_range(0, 1)), rand_vec(), rand_vec(), ($urandom_range(0, 3) == 0));
    end
    bus.in_valid  = 1'b0;
    rand_ordy     = 1'b0;
    bus.out_ready = 1'b1;
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
